// File: rtl/dual_intf_arbiter_if.sv
// Handshake bundle between two requesters and the shared output port
// of dual_intf_arbiter.
interface dual_intf_arbiter_if #(
    parameter int DW = 32
);
    logic          req0;
    logic [DW-1:0] data0;
    logic          last0;
    logic          gnt0;
    logic          req1;
    logic [DW-1:0] data1;
    logic          last1;
    logic          gnt1;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          out_src;
    logic          busy;

    // Requesters and downstream sink side
    modport master (
        output req0, data0, last0, req1, data1, last1, out_ready,
        input  gnt0, gnt1, out_valid, out_data, out_src, busy
    );

    // Arbiter side
    modport slave (
        input  req0, data0, last0, req1, data1, last1, out_ready,
        output gnt0, gnt1, out_valid, out_data, out_src, busy
    );
endinterface

// File: rtl/dual_intf_arbiter.sv
// Two-requester burst arbiter onto one shared port. A grant lasts until a
// last beat, MAX_BURST beats, or the owner dropping its request; every
// release passes through IDLE and hands priority to the other requester.
module dual_intf_arbiter #(
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    dual_intf_arbiter_if.slave  bus
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          prio, prio_nxt;
    logic [BW-1:0] bcnt, bcnt_nxt;
    logic [BW-1:0] bcnt_inc;

    logic          cur_idx;
    logic          cur_req;
    logic          cur_last;
    logic [DW-1:0] cur_data;
    logic          xfer;

    logic          out_valid_c;
    logic [DW-1:0] out_data_c;
    logic          out_src_c;

    // State, priority pointer and beat counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prio  <= 1'b0;
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    // Next-state, release decisions and shared-port mux
    always_comb begin
        state_nxt   = state;
        prio_nxt    = prio;
        bcnt_nxt    = bcnt;
        bcnt_inc    = bcnt + BW'(1);
        cur_idx     = (state == OWN1);
        cur_req     = cur_idx ? bus.req1  : bus.req0;
        cur_last    = cur_idx ? bus.last1 : bus.last0;
        cur_data    = cur_idx ? bus.data1 : bus.data0;
        xfer        = 1'b0;
        out_valid_c = 1'b0;
        out_data_c  = '0;
        out_src_c   = prio;

        case (state)
            IDLE: begin
                bcnt_nxt = '0;
                if (bus.req0 && bus.req1) begin
                    state_nxt = prio ? OWN1 : OWN0;
                end else if (bus.req0) begin
                    state_nxt = OWN0;
                end else if (bus.req1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0, OWN1: begin
                out_valid_c = cur_req;
                out_data_c  = cur_data;
                out_src_c   = cur_idx;
                xfer        = cur_req && bus.out_ready;
                if (xfer) begin
                    bcnt_nxt = bcnt_inc;
                    if (cur_last || (bcnt_inc == MAX_CNT)) begin
                        state_nxt = IDLE;
                        prio_nxt  = ~cur_idx;
                        bcnt_nxt  = '0;
                    end
                end else if (!cur_req) begin
                    // owner withdrew with no beat accepted: abort the grant
                    state_nxt = IDLE;
                    prio_nxt  = ~cur_idx;
                    bcnt_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                bcnt_nxt  = '0;
            end
        endcase
    end

    assign bus.gnt0      = (state == OWN0);
    assign bus.gnt1      = (state == OWN1);
    assign bus.busy      = (state == OWN0) || (state == OWN1);
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_c;
    assign bus.out_src   = out_src_c;
endmodule

// File: doc/dual_intf_arbiter.md
DUAL_INTF_ARBITER -- requirements
Module: dual_intf_arbiter

Interface
REQ-001 Parameter DW, default 32: data width of each requester and of the shared output port.
REQ-002 Parameter MAX_BURST, default 4: maximum beats per grant; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0  input  1  requester 0 has a valid beat.
REQ-006 data0  input  DW  requester 0 beat data.
REQ-007 last0  input  1  requester 0 beat is the final beat of its burst.
REQ-008 gnt0  output  1  requester 0 owns the shared port.
REQ-009 req1, data1, last1, gnt1: same as REQ-005..REQ-008, for requester 1.
REQ-010 out_valid  output  1  shared port beat valid.
REQ-011 out_data  output  DW  shared port beat data.
REQ-012 out_ready  input  1  shared port accepts the beat.
REQ-013 out_src  output  1  index of the requester driving the shared port.
REQ-014 busy  output  1  a grant is active.

Function
REQ-015 FSM states SHALL be IDLE, OWN0 and OWN1, with a registered 1-bit priority pointer prio (0 = requester 0 preferred).
REQ-016 IDLE: if only one req is high, that requester SHALL be granted next cycle; if both are high, requester prio SHALL be granted; if neither is high, the FSM SHALL stay in IDLE.
REQ-017 Grant latency SHALL be exactly 1 cycle from req sampled high in IDLE to gntN high.
REQ-018 gnt0 = (state==OWN0), gnt1 = (state==OWN1) and busy = gnt0|gnt1, all decoded from registered state; gnt0 and gnt1 SHALL never both be high.
REQ-019 While OWNn, out_valid = reqn, out_data = datan and out_src = n, combinationally; in IDLE, out_valid = 0, out_data = 0 and out_src = prio.
REQ-020 A beat SHALL transfer on a cycle where out_valid && out_ready; the beat counter bcnt (width clog2(MAX_BURST+1)) SHALL increment on each transfer and clear on entry to IDLE.
REQ-021 A grant SHALL release (next state IDLE) on a transfer with lastn=1, or on the transfer that makes bcnt==MAX_BURST, whichever comes first.
REQ-022 If reqn drops while OWNn with no transfer in that cycle, the grant SHALL release next cycle (abort); the beats already transferred are not undone.
REQ-023 On every release, prio SHALL be set to the other requester (~n).
REQ-024 The FSM SHALL return through IDLE for at least 1 cycle between grants: there is no back-to-back OWN0->OWN1 in consecutive cycles.
REQ-025 A stalled beat (out_valid=1, out_ready=0) SHALL hold the grant indefinitely; there is no timeout.
REQ-026 Requesters SHALL hold data and last stable while reqn=1 and the beat is not transferred; the arbiter does not buffer data.

Reset
REQ-027 While rst=1 at a clock edge, next state SHALL be: state=IDLE, prio=0, bcnt=0.
REQ-028 After reset, the outputs SHALL be gnt0=0, gnt1=0, busy=0, out_valid=0, out_data=0, out_src=0.
REQ-029 Reset asserted mid-burst SHALL drop the grant on the next edge regardless of out_ready or last, with no further transfers counted.

Verification
REQ-030 Reset, then req0=1 alone with data0=0xA5, last0=1, out_ready=1 -> gnt0 high on cycle 1, one transfer with out_data=0xA5 and out_src=0, IDLE on cycle 2, prio=1.
REQ-031 req0=req1=1 continuously, last=1 every beat -> grants alternate 0,1,0,1 separated by 1 IDLE cycle each; gnt0 and gnt1 never both high.
REQ-032 req1=1, last1=0 always, out_ready=1, MAX_BURST=4 -> exactly 4 transfers, then forced release, prio=0.
REQ-033 OWN0 with out_ready=0 for 10 cycles -> gnt0 held, out_valid=1, bcnt unchanged; out_ready=1 with last0=1 -> release.
REQ-034 OWN1 after 2 beats, req1 dropped with no transfer -> IDLE next cycle, bcnt=0, prio=0.
REQ-035 rst pulsed for 1 cycle during OWN0 beat 2 -> all outputs at reset values next cycle, prio=0; a subsequent req1 is granted normally.
